// File: rtl/main_memory_pkg.sv
// Shared defaults and types for the main_memory block.
package main_memory_pkg;

    localparam int unsigned MM_ADDR_WIDTH = 8;
    localparam int unsigned MM_DATA_WIDTH = 8;
    localparam logic [MM_DATA_WIDTH-1:0] MM_INIT_VALUE = 8'h00;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mm_state_t;

endpackage : main_memory_pkg

// File: rtl/main_memory_array.sv
// Plain single-port storage array with a write-first registered read port.
// The storage itself is never reset; only the read register can be cleared.
module main_memory_array #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  rd_clr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Registered read; a write on the same edge forwards its data.
    always_ff @(posedge clk) begin
        if (rd_clr_i) begin
            rdata_q <= '0;
        end else if (we_i) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : main_memory_array

// File: rtl/main_memory.sv
// Main memory behind the cache controller: post-reset init sweep, then a
// single-port write-first RAM with registered read data.
// Optional macro OUTREG_EN adds a second output register (latency 2).
module main_memory
    import main_memory_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = MM_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = MM_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(MM_INIT_VALUE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  ready
);

    mm_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;

    logic                  mem_we_c;
    logic                  rd_clr_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic [DATA_WIDTH-1:0] rdata;

    // State, sweep counter and ready flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Next state and the mux between sweep writes and user accesses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        mem_we_c    = 1'b0;
        rd_clr_c    = 1'b0;
        mem_addr_c  = address;
        mem_wdata_c = data;

        unique case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                rd_clr_c    = 1'b1;
                mem_addr_c  = cnt_q;
                mem_wdata_c = INIT_VALUE;
                cnt_d       = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end
            ST_READY: begin
                mem_we_c = wren;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // The reset edge itself performs no access and clears read data.
        if (reset) begin
            mem_we_c = 1'b0;
            rd_clr_c = 1'b1;
        end
    end

    main_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk      (clock),
        .we_i     (mem_we_c),
        .rd_clr_i (rd_clr_c),
        .addr_i   (mem_addr_c),
        .wdata_i  (mem_wdata_c),
        .rdata_o  (rdata)
    );

`ifdef OUTREG_EN
    logic [DATA_WIDTH-1:0] q2_q;

    // Second output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            q2_q <= '0;
        end else begin
            q2_q <= rdata;
        end
    end

    assign q = q2_q;
`else
    assign q = rdata;
`endif

    assign ready = ready_q;

endmodule : main_memory

// File: tb/tb_main_memory.sv
// Directed self-checking bench for main_memory.
module tb_main_memory;

`ifdef OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] address;
    logic [7:0] data;
    logic       wren;
    logic [7:0] q;
    logic       ready;

    int total = 0;
    int bad   = 0;

    main_memory dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .ready   (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One rising edge, then settle 2 time units before sampling.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wren = 1'b1; address = a; data = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        wren = 1'b0; address = a;
        for (int k = 0; k < LAT; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; wren = 1'b0; address = 8'h00; data = 8'h00;
        tick();
        tick();
        total++;
        if (q !== 8'h00 || ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: q=%h ready=%b, expected q=00 ready=0", q, ready);
        end
        reset = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            total++;
            if (ready !== (i == 256) || q !== 8'h00) begin
                bad++;
                $display("FAIL init_sweep edge %0d: ready=%b q=%h, expected ready=%b q=00",
                         i, ready, q, (i == 256));
            end
        end
    endtask

    task automatic test_init_reads();
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            rd(addrs[i]);
            total++;
            if (q !== 8'h00) begin
                bad++;
                $display("FAIL init_read @%h: got %h expected 00", addrs[i], q);
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] ra [3];
        logic [7:0] rexp [3];
        wr(8'h00, 8'h05);
        wr(8'h02, 8'h01);
        wr(8'h01, 8'h03);
        ra[0] = 8'h00; rexp[0] = 8'h05;
        ra[1] = 8'h02; rexp[1] = 8'h01;
        ra[2] = 8'h01; rexp[2] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            rd(ra[i]);
            total++;
            if (q !== rexp[i]) begin
                bad++;
                $display("FAIL write_read @%h: got %h expected %h", ra[i], q, rexp[i]);
            end
        end
    endtask

    task automatic test_write_first();
        wren = 1'b1; address = 8'h10; data = 8'hA5;
        for (int k = 0; k < LAT; k++) tick();
        wren = 1'b0;
        total++;
        if (q !== 8'hA5) begin
            bad++;
            $display("FAIL write_first: got %h expected a5", q);
        end
        rd(8'h10);
        total++;
        if (q !== 8'hA5) begin
            bad++;
            $display("FAIL write_first_readback: got %h expected a5", q);
        end
    endtask

    task automatic test_back_to_back();
        wr(8'h30, 8'h5A);
        rd(8'h30);
        total++;
        if (q !== 8'h5A) begin
            bad++;
            $display("FAIL back_to_back: got %h expected 5a", q);
        end
        wr(8'h31, 8'hC3);
        wr(8'h31, 8'h3C);
        rd(8'h31);
        total++;
        if (q !== 8'h3C) begin
            bad++;
            $display("FAIL overwrite: got %h expected 3c", q);
        end
    endtask

    task automatic test_latency();
        rd(8'h02);
        wren = 1'b0; address = 8'h00;
        tick();
        total++;
`ifdef OUTREG_EN
        if (q !== 8'h01) begin
            bad++;
            $display("FAIL latency_edge1: got %h expected 01 (old data)", q);
        end
        tick();
        total++;
`endif
        if (q !== 8'h05) begin
            bad++;
            $display("FAIL latency_final: got %h expected 05", q);
        end
    endtask

    task automatic test_reset_midsweep();
        wr(8'h40, 8'h33);
        rd(8'h40);
        total++;
        if (q !== 8'h33) begin
            bad++;
            $display("FAIL pre_reset_read: got %h expected 33", q);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wren = 1'b1; address = 8'h20; data = 8'hFF;
        for (int i = 0; i < 100; i++) tick();
        total++;
        if (ready !== 1'b0 || q !== 8'h00) begin
            bad++;
            $display("FAIL mid_sweep: ready=%b q=%h expected ready=0 q=00", ready, q);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            total++;
            if (ready !== (i == 256) || q !== 8'h00) begin
                bad++;
                $display("FAIL restart_sweep edge %0d: ready=%b q=%h expected ready=%b q=00",
                         i, ready, q, (i == 256));
            end
        end
        wren = 1'b0;
        rd(8'h40);
        total++;
        if (q !== 8'h00) begin
            bad++;
            $display("FAIL reinit_read40: got %h expected 00", q);
        end
        rd(8'h20);
        total++;
        if (q !== 8'h00) begin
            bad++;
            $display("FAIL ignored_init_write: got %h expected 00", q);
        end
        rd(8'h00);
        total++;
        if (q !== 8'h00) begin
            bad++;
            $display("FAIL reinit_read00: got %h expected 00", q);
        end
    endtask

    initial begin
        test_reset();
        test_init_reads();
        test_write_read();
        test_write_first();
        test_back_to_back();
        test_latency();
        test_reset_midsweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_main_memory
